// File: rtl/ibex_load_resp_unit.sv
// ibex_load_resp_unit
//
// Tracks one outstanding load/store and turns its data-bus response beats
// into the LSU writeback signals. Load data is aligned and sign- or
// zero-extended. A misaligned access that the LSU splits into two bus
// transactions is merged from two response beats.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i/ready_o  access descriptor handshake from EX
//   req_we_i             1 = store, 0 = load
//   req_type_i           00 word, 01 half, 10 byte, 11 treated as word
//   req_sign_ext_i       sign-extend load data
//   req_offset_i         address bits [1:0]
//   data_rvalid_i        bus response beat
//   data_rdata_i         response read data
//   data_err_i           response error
//   rf_wdata_lsu_o       aligned load result (0 when rf_we_lsu_o is 0)
//   rf_we_lsu_o          register-file write enable for load data
//   lsu_resp_valid_o     access complete (one pulse, on the final beat)
//   lsu_resp_err_o       access completed with error
//   busy_o               an access is outstanding
//
// Handshake: a descriptor transfers on a rising clock edge where both
// req_valid_i and req_ready_o are high. req_ready_o is high in IDLE and in
// the final-beat cycle, so a new access may be accepted in the same cycle
// the previous one completes. req_ready_o depends combinationally on
// data_rvalid_i; req_valid_i must not depend on req_ready_o. There is no
// ready on the response side: every data_rvalid_i beat is consumed.

module ibex_load_resp_unit #(
    parameter logic SplitEnable = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_FIRST  = 2'd1,
        WAIT_SECOND = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  offset_q, offset_d;
    logic        split_q, split_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_is_word, req_is_half, req_split;
    logic        final_beat, accept;
    logic        is_byte_q, is_half_q;
    logic [31:0] shifted, merged, raw, extended;
    logic        resp_err, load_we;

    // Type 11 is illegal and falls through to word handling.
    assign req_is_half = (req_type_i == 2'b01);
    assign req_is_word = (req_type_i != 2'b01) && (req_type_i != 2'b10);
    assign req_split   = SplitEnable &
                         ((req_is_word && (req_offset_i != 2'd0)) ||
                          (req_is_half && (req_offset_i == 2'd3)));

    assign is_half_q = (type_q == 2'b01);
    assign is_byte_q = (type_q == 2'b10);

    assign final_beat = data_rvalid_i &&
                        (((state_q == WAIT_FIRST) && !split_q) ||
                         (state_q == WAIT_SECOND));

    assign req_ready_o = (state_q == IDLE) || final_beat;
    assign accept      = req_valid_i && req_ready_o;
    assign busy_o      = (state_q != IDLE);

    // Next-state and descriptor capture.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        type_d     = type_q;
        sign_ext_d = sign_ext_q;
        offset_d   = offset_q;
        split_d    = split_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                // data_rvalid_i here is spurious and deliberately ignored.
                if (accept) state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
                    if (split_q) begin
                        // First half of a split: hold it until beat two.
                        rdata_d = data_rdata_i;
                        err_d   = data_err_i;
                        state_d = WAIT_SECOND;
                    end else begin
                        state_d = accept ? WAIT_FIRST : IDLE;
                    end
                end
            end
            WAIT_SECOND: begin
                if (data_rvalid_i) state_d = accept ? WAIT_FIRST : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            we_d       = req_we_i;
            type_d     = req_type_i;
            sign_ext_d = req_sign_ext_i;
            offset_d   = req_offset_i;
            split_d    = req_split;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            type_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            offset_q   <= 2'd0;
            split_q    <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            type_q     <= type_d;
            sign_ext_q <= sign_ext_d;
            offset_q   <= offset_d;
            split_q    <= split_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Aligned path: move the addressed byte lane down to bit 0.
    assign shifted = data_rdata_i >> {offset_q, 3'b000};

    // Split path: upper bytes of the first beat sit at the bottom, low bytes
    // of the second beat on top. For a half at offset 3 the low 16 bits of
    // the offset-3 word merge are exactly {d[7:0], q[31:24]}.
    always_comb begin
        case (offset_q)
            2'd1:    merged = {data_rdata_i[7:0],  rdata_q[31:8]};
            2'd2:    merged = {data_rdata_i[15:0], rdata_q[31:16]};
            2'd3:    merged = {data_rdata_i[23:0], rdata_q[31:24]};
            default: merged = data_rdata_i;
        endcase
    end

    // rdata_q[7:0] never lands in any merge result.
    logic unused_rdata_low;
    assign unused_rdata_low = ^rdata_q[7:0];

    assign raw = split_q ? merged : shifted;

    always_comb begin
        if (is_byte_q) begin
            extended = {{24{sign_ext_q & raw[7]}}, raw[7:0]};
        end else if (is_half_q) begin
            extended = {{16{sign_ext_q & raw[15]}}, raw[15:0]};
        end else begin
            extended = raw;
        end
    end

    // A first-beat error is remembered and reported only at completion.
    assign resp_err = data_err_i || (split_q && err_q);
    assign load_we  = final_beat && !we_q && !resp_err;

    assign lsu_resp_valid_o = final_beat;
    assign lsu_resp_err_o   = final_beat && resp_err;
    assign rf_we_lsu_o      = load_we;
    // Zero unless writing, so the writeback OR-mux sees no stray bits.
    assign rf_wdata_lsu_o   = load_we ? extended : 32'h0;

`ifndef SYNTHESIS
    // A response with nothing outstanding indicates a bus-side protocol slip.
    spurious_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && (state_q == IDLE)))
        else $warning("ibex_load_resp_unit: data_rvalid_i in IDLE ignored");
`endif

endmodule

// File: tb/tb_ibex_load_resp_unit.sv
// Directed testbench for ibex_load_resp_unit. Inputs change just after the
// falling edge; outputs are checked 1 ns later, well away from the rising
// edge. A second instance covers SplitEnable = 0.

module tb_ibex_load_resp_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_sign_ext, rvalid, rerr;
    logic [1:0]  req_type, req_offset;
    logic [31:0] rdata;

    logic        ready, we_lsu, resp_valid, resp_err, busy;
    logic [31:0] wdata;

    logic        b_req_valid, b_rvalid;
    logic        b_ready, b_we_lsu, b_resp_valid, b_resp_err, b_busy;
    logic [31:0] b_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_load_resp_unit #(.SplitEnable(1'b1)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (ready),
        .req_we_i         (req_we),
        .req_type_i       (req_type),
        .req_sign_ext_i   (req_sign_ext),
        .req_offset_i     (req_offset),
        .data_rvalid_i    (rvalid),
        .data_rdata_i     (rdata),
        .data_err_i       (rerr),
        .rf_wdata_lsu_o   (wdata),
        .rf_we_lsu_o      (we_lsu),
        .lsu_resp_valid_o (resp_valid),
        .lsu_resp_err_o   (resp_err),
        .busy_o           (busy)
    );

    ibex_load_resp_unit #(.SplitEnable(1'b0)) dut_nosplit (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (b_req_valid),
        .req_ready_o      (b_ready),
        .req_we_i         (req_we),
        .req_type_i       (req_type),
        .req_sign_ext_i   (req_sign_ext),
        .req_offset_i     (req_offset),
        .data_rvalid_i    (b_rvalid),
        .data_rdata_i     (rdata),
        .data_err_i       (rerr),
        .rf_wdata_lsu_o   (b_wdata),
        .rf_we_lsu_o      (b_we_lsu),
        .lsu_resp_valid_o (b_resp_valid),
        .lsu_resp_err_o   (b_resp_err),
        .busy_o           (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus to the main instance and settle.
    task automatic drive(input logic rq, input logic we, input logic [1:0] ty,
                         input logic sx, input logic [1:0] off,
                         input logic rv, input logic [31:0] rd,
                         input logic er);
        @(negedge clk);
        req_valid    = rq;
        req_we       = we;
        req_type     = ty;
        req_sign_ext = sx;
        req_offset   = off;
        rvalid       = rv;
        rdata        = rd;
        rerr         = er;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        b_req_valid = 1'b0;
        b_rvalid    = 1'b0;
        idle();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Reset state
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_we", 32'(we_lsu), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_wdata", wdata, 32'h0);

        // Signed byte load, offset 2
        drive(1'b1, 1'b0, 2'b10, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        check("sb_ready", 32'(ready), 32'd1);
        drive(1'b0, 1'b0, 2'b10, 1'b1, 2'd2, 1'b1, 32'h0080_0000, 1'b0);
        check("sb_busy", 32'(busy), 32'd1);
        check("sb_valid", 32'(resp_valid), 32'd1);
        check("sb_we", 32'(we_lsu), 32'd1);
        check("sb_wdata", wdata, 32'hFFFF_FF80);
        idle();
        check("sb_idle_busy", 32'(busy), 32'd0);

        // Split word load, offset 1
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 32'hAABB_CCDD, 1'b0);
        check("sw_b1_valid", 32'(resp_valid), 32'd0);
        check("sw_b1_busy", 32'(busy), 32'd1);
        check("sw_b1_ready", 32'(ready), 32'd0);
        check("sw_b1_we", 32'(we_lsu), 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 32'h1122_3344, 1'b0);
        check("sw_b2_valid", 32'(resp_valid), 32'd1);
        check("sw_b2_we", 32'(we_lsu), 32'd1);
        check("sw_b2_wdata", wdata, 32'h44AA_BBCC);
        idle();
        check("sw_idle_busy", 32'(busy), 32'd0);

        // Split half load, offset 3, unsigned, error on beat 1
        drive(1'b1, 1'b0, 2'b01, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b01, 1'b0, 2'd3, 1'b1, 32'hFF00_0000, 1'b1);
        check("sh_b1_valid", 32'(resp_valid), 32'd0);
        check("sh_b1_err", 32'(resp_err), 32'd0);
        drive(1'b0, 1'b0, 2'b01, 1'b0, 2'd3, 1'b1, 32'h0000_00FF, 1'b0);
        check("sh_b2_valid", 32'(resp_valid), 32'd1);
        check("sh_b2_err", 32'(resp_err), 32'd1);
        check("sh_b2_we", 32'(we_lsu), 32'd0);
        check("sh_b2_wdata", wdata, 32'h0);
        idle();

        // Back-to-back: store completes while a load is accepted
        drive(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("b2b_ready", 32'(ready), 32'd1);
        check("b2b_st_valid", 32'(resp_valid), 32'd1);
        check("b2b_st_we", 32'(we_lsu), 32'd0);
        check("b2b_st_wdata", wdata, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        check("b2b_wf_busy", 32'(busy), 32'd1);
        check("b2b_wf_valid", 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hCAFE_F00D, 1'b0);
        check("b2b_ld_valid", 32'(resp_valid), 32'd1);
        check("b2b_ld_we", 32'(we_lsu), 32'd1);
        check("b2b_ld_wdata", wdata, 32'hCAFE_F00D);

        // Signed half at offset 2, unsigned byte at offset 1
        drive(1'b1, 1'b0, 2'b01, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b01, 1'b1, 2'd2, 1'b1, 32'h8001_1234, 1'b0);
        check("shs_wdata", wdata, 32'hFFFF_8001);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 2'd1, 1'b1, 32'h0000_AB00, 1'b0);
        check("ubz_wdata", wdata, 32'h0000_00AB);
        idle();

        // Spurious rvalid in IDLE
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("sp_valid", 32'(resp_valid), 32'd0);
        check("sp_we", 32'(we_lsu), 32'd0);
        check("sp_err", 32'(resp_err), 32'd0);
        check("sp_wdata", wdata, 32'h0);
        idle();
        check("sp_busy", 32'(busy), 32'd0);

        // Reset after beat 1 of a split word load
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd2, 1'b1, 32'h5566_7788, 1'b0);
        check("rm_b1_valid", 32'(resp_valid), 32'd0);
        idle();
        check("rm_ws_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        #1;
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_ready", 32'(ready), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'd2, 1'b1, 32'h1234_5678, 1'b0);
        check("rm_late_valid", 32'(resp_valid), 32'd0);
        check("rm_late_wdata", wdata, 32'h0);
        idle();
        check("rm_late_busy", 32'(busy), 32'd0);

        // SplitEnable = 0: word load at offset 2 completes on one beat
        @(negedge clk);
        b_req_valid  = 1'b1;
        req_we       = 1'b0;
        req_type     = 2'b00;
        req_sign_ext = 1'b0;
        req_offset   = 2'd2;
        #1;
        check("ns_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        b_req_valid = 1'b0;
        b_rvalid    = 1'b1;
        rdata       = 32'h1122_3344;
        rerr        = 1'b0;
        #1;
        check("ns_valid", 32'(b_resp_valid), 32'd1);
        check("ns_we", 32'(b_we_lsu), 32'd1);
        check("ns_err", 32'(b_resp_err), 32'd0);
        check("ns_wdata", b_wdata, 32'h0000_1122);
        @(negedge clk);
        b_rvalid = 1'b0;
        #1;
        check("ns_busy", 32'(b_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
